inst_enc: RTL and testbench
===========================

# inst_enc

- Pipelined RV32I instruction encoder; inverse of the core's immediate extractor.
- Accepts decoded fields (opcode, registers, functs, 32-bit immediate) over a valid/ready handshake and emits the packed 32-bit instruction word.
- Flags immediates the selected format cannot represent, and unsupported opcodes.
- Sits between the debug/boot instruction injector and the instruction memory write port; also used by the verification bench to round-trip the immediate extractor.

## Interface
- `CNT_W`, default 16: width of the encoded-instruction counter.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input fields valid
- `in_ready`  out  1  encoder can accept
- `opcode`  in  7  RV32I major opcode
- `rd`, `rs1`, `rs2`  in  5 each  register indices
- `funct3`  in  3; `funct7`  in  7
- `imm`  in  32  immediate, in the same bit positions the extractor produces
- `out_valid`  out  1  `instOut` valid
- `out_ready`  in  1  downstream accepts
- `instOut`  out  32  packed instruction
- `out_err`  out  2  bit0 = range error, bit1 = unsupported opcode
- `enc_count`  out  `CNT_W`  accepted-instruction count, wraps
- `err_count`  out  8  errored-instruction count, saturates at 255

## Operation
- Packing by opcode; `instOut[6:0]` = opcode in all cases.
- **LUI 0110111 / AUIPC 0010111:** [31:12]=imm[31:12], [11:7]=rd. Range error if imm[11:0]≠0.
- **JAL 1101111:** [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd. Error if imm[0]=1 or imm[31:21] not all equal to imm[20].
- **JALR 1100111 / LOAD 0000011 / OP-IMM 0010011 (non-shift):** [31:20]=imm[11:0], rs1, funct3, rd. Error if imm[31:12] not all equal to imm[11].
- **OP-IMM shift (funct3 = 001 or 101):** [31:25]=funct7, [24:20]=imm[4:0]. Error if imm[31:5]≠0.
- **STORE 0100011:** [31:25]=imm[11:5], rs2, rs1, funct3, [11:7]=imm[4:0]. Error if imm[31:12] not all equal to imm[11].
- **BRANCH 1100011:** [31]=imm[12], [30:25]=imm[10:5], rs2, rs1, funct3, [11:8]=imm[4:1], [7]=imm[11]. Error if imm[0]=1 or imm[31:13] not all equal to imm[12].
- **OP 0110011:** funct7, rs2, rs1, funct3, rd; imm ignored.
- **Any other opcode:** `instOut` = 32'h00000013 (NOP), `out_err[1]`=1.
- On range error the truncated fields are still packed; only the flag marks the error.
- Counters:
  - `enc_count` increments on every input handshake.
  - `err_count` increments when a word with `out_err`≠0 is handed off at the output.

## Timing
- Two register stages:
  - S1 captures the input fields.
  - S2 holds packed `instOut`/`out_err`.
- Latency: handshake at cycle N → `out_valid` at N+2 when `out_ready` stays high.
- Throughput: one instruction per cycle.
- `in_ready` = !s1_valid | !s2_valid | out_ready; it is combinational from `out_ready`.
- S2 loads from S1 when !s2_valid | out_ready.
- Output stability: while out_valid & !out_ready, `instOut`/`out_err` hold stable.
- Capacity: at most two words are buffered under backpressure; order is preserved and no word is dropped or duplicated.
- Simultaneous output handoff and new input: both occur in the same cycle, and the pipeline advances.
- Reset values: s1_valid=0, s2_valid=0, `out_valid`=0, `instOut`=0, `out_err`=0, `enc_count`=0, `err_count`=0.
- Reset mid-operation discards both stages. `in_ready`=1 in the first cycle after reset.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode constants: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP
  - the NOP constant
  - the `out_err` bit indices
- The extractor migrates to these constants as well.
- One sub-module, `inst_pack`: purely combinational field packing and range check, placed between S1 and S2. Pipeline control and counters live in `inst_enc`.

## Test plan
- LUI, rd=5, imm=0x12345000 → `instOut`=0x123452B7, `out_err`=0, `out_valid` exactly 2 cycles after accept.
- ADDI, rd=1, rs1=0, imm=0xFFFFFFFF → 0xFFF00093. Same with imm=0x00000800 → `out_err`=01, `err_count`=1.
- BEQ, rs1=1, rs2=2, imm=8 → 0x00208463. Same with imm=7 → `out_err[0]`=1.
- SLLI (funct3=001), imm=32 → range error. Opcode 0x7F → NOP 0x00000013, `out_err`=10.
- Backpressure:
  - Stimulus: `out_ready` low for 3 cycles while 4 back-to-back inputs are offered.
  - Required: `in_ready` drops after 2 accepts; all 4 outputs emerge in order; `enc_count`=4.
- Round-trip and reset:
  - Random legal field sets through `inst_enc` then the extractor → immediate matches the input.
  - Reset with both stages full → `out_valid`=0 next cycle, both counters 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants: major opcodes, canonical NOP, error flag bits.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // out_err bit positions
    localparam int ERR_RANGE_BIT = 0;
    localparam int ERR_OPC_BIT   = 1;

    // Decoded instruction fields as captured by the first pipeline stage.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // SLLI/SRLI/SRAI carry a 5-bit shamt instead of a 12-bit immediate.
    function automatic logic is_shift(input logic [6:0] opc, input logic [2:0] f3);
        return (opc == OPC_OPIMM) && (f3[1:0] == 2'b01);
    endfunction

endpackage

// File: rtl/inst_enc_if.sv
// Encoder bus: valid/ready field input, valid/ready packed-word output, counters.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the sink throttles in_ready toward the source.
// Ports: master = field source / word sink side, slave = the encoder.
interface inst_enc_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instOut;
    logic [1:0]       out_err;
    logic [CNT_W-1:0] enc_count;
    logic [7:0]       err_count;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instOut, out_err, enc_count, err_count
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instOut, out_err, enc_count, err_count
    );
endinterface

// File: rtl/inst_enc_pack.sv
// Combinational RV32I field packer with immediate range check.
// Latency: 0 cycles (pure combinational, sits between S1 and S2).
// Backpressure: none; the enclosing pipeline decides when the result is taken.
// Ports: fld_i decoded fields in; inst_o packed word, err_o {bad opcode, range}.
module inst_pack
    import rv32i_pkg::*;
(
    input  fields_t     fld_i,
    output logic [31:0] inst_o,
    output logic [1:0]  err_o
);

    logic [31:0] imm;
    logic        i_imm_bad;

    assign imm = fld_i.imm;
    // 12-bit signed immediates (I and S formats) must be sign-extended from bit 11.
    assign i_imm_bad = (imm[31:12] != {20{imm[11]}});

    always_comb begin
        inst_o = INST_NOP;
        err_o  = '0;
        case (fld_i.opcode)
            OPC_LUI, OPC_AUIPC: begin
                inst_o = {imm[31:12], fld_i.rd, fld_i.opcode};
                err_o[ERR_RANGE_BIT] = |imm[11:0];
            end
            OPC_JAL: begin
                inst_o = {imm[20], imm[10:1], imm[11], imm[19:12], fld_i.rd, fld_i.opcode};
                err_o[ERR_RANGE_BIT] = imm[0] | (imm[31:21] != {11{imm[20]}});
            end
            OPC_JALR, OPC_LOAD: begin
                inst_o = {imm[11:0], fld_i.rs1, fld_i.funct3, fld_i.rd, fld_i.opcode};
                err_o[ERR_RANGE_BIT] = i_imm_bad;
            end
            OPC_OPIMM: begin
                if (is_shift(fld_i.opcode, fld_i.funct3)) begin
                    inst_o = {fld_i.funct7, imm[4:0], fld_i.rs1, fld_i.funct3, fld_i.rd,
                              fld_i.opcode};
                    err_o[ERR_RANGE_BIT] = |imm[31:5];
                end else begin
                    inst_o = {imm[11:0], fld_i.rs1, fld_i.funct3, fld_i.rd, fld_i.opcode};
                    err_o[ERR_RANGE_BIT] = i_imm_bad;
                end
            end
            OPC_STORE: begin
                inst_o = {imm[11:5], fld_i.rs2, fld_i.rs1, fld_i.funct3, imm[4:0], fld_i.opcode};
                err_o[ERR_RANGE_BIT] = i_imm_bad;
            end
            OPC_BRANCH: begin
                inst_o = {imm[12], imm[10:5], fld_i.rs2, fld_i.rs1, fld_i.funct3, imm[4:1],
                          imm[11], fld_i.opcode};
                err_o[ERR_RANGE_BIT] = imm[0] | (imm[31:13] != {19{imm[12]}});
            end
            OPC_OP: begin
                inst_o = {fld_i.funct7, fld_i.rs2, fld_i.rs1, fld_i.funct3, fld_i.rd,
                          fld_i.opcode};
            end
            default: begin
                inst_o = INST_NOP;
                err_o[ERR_OPC_BIT] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_enc.sv
// Two-stage RV32I instruction encoder: S1 holds fields, S2 holds packed word/flags.
// Latency: 2 cycles from input handshake to out_valid; one instruction per cycle.
// Backpressure: in_ready = !s1_vld | !s2_vld | out_ready (combinational); holds 2 words.
// Ports: clk, rst (sync active-high), bus (slave side of inst_enc_if).
module inst_enc
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    inst_enc_if.slave bus
);

    fields_t          s1_q, s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;
    logic [31:0]      s2_inst_q, s2_inst_d;
    logic [1:0]       s2_err_q, s2_err_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [7:0]       err_count_q, err_count_d;

    logic             in_rdy;
    logic             in_hs;
    logic             out_hs;
    logic             s2_load;
    logic [31:0]      pk_inst;
    logic [1:0]       pk_err;

    inst_pack u_pack (
        .fld_i  (s1_q),
        .inst_o (pk_inst),
        .err_o  (pk_err)
    );

    // S2 can take a word when empty or when its current word leaves this cycle.
    assign s2_load = !s2_vld_q || bus.out_ready;
    // S1 is free when empty, or when its word moves into S2 this cycle.
    assign in_rdy  = !s1_vld_q || !s2_vld_q || bus.out_ready;
    assign in_hs   = bus.in_valid && in_rdy;
    assign out_hs  = s2_vld_q && bus.out_ready;

    always_comb begin
        s1_d        = s1_q;
        s1_vld_d    = s1_vld_q;
        s2_vld_d    = s2_vld_q;
        s2_inst_d   = s2_inst_q;
        s2_err_d    = s2_err_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;

        if (in_hs) begin
            s1_d.opcode = bus.opcode;
            s1_d.rd     = bus.rd;
            s1_d.rs1    = bus.rs1;
            s1_d.rs2    = bus.rs2;
            s1_d.funct3 = bus.funct3;
            s1_d.funct7 = bus.funct7;
            s1_d.imm    = bus.imm;
            s1_vld_d    = 1'b1;
            enc_count_d = enc_count_q + 1'b1;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end

        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_inst_d = pk_inst;
                s2_err_d  = pk_err;
            end
        end

        if (out_hs && (s2_err_q != 2'b00) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_inst_q   <= '0;
            s2_err_q    <= '0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_vld_q    <= s1_vld_d;
            s2_vld_q    <= s2_vld_d;
            s2_inst_q   <= s2_inst_d;
            s2_err_q    <= s2_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_vld_q;
    assign bus.instOut   = s2_inst_q;
    assign bus.out_err   = s2_err_q;
    assign bus.enc_count = enc_count_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_inst_enc.sv
// Directed + random bench for inst_enc with an output scoreboard and immediate extractor.
module tb_inst_enc;
    import rv32i_pkg::*;

    typedef struct {
        logic        rt;     // 1: round-trip check via extractor, 0: exact word check
        logic [31:0] inst;
        logic [1:0]  err;
        logic [6:0]  opc;
        logic [31:0] imm;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_enc_if #(.CNT_W(16)) bus ();

    inst_enc #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sb_t  q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   exp_enc  = 0;
    int   exp_errc = 0;
    int   lo_cnt   = 0;
    bit   rand_rdy = 1'b0;
    bit   stalled  = 1'b0;
    logic [31:0] held_inst;
    logic [1:0]  held_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference immediate extractor (decoder side of the round trip).
    function automatic logic [31:0] extract(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (w[6:0])
            OPC_LUI, OPC_AUIPC: r = {w[31:12], 12'b0};
            OPC_JAL:            r = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            OPC_JALR, OPC_LOAD: r = {{20{w[31]}}, w[31:20]};
            OPC_OPIMM:          r = (w[13:12] == 2'b01) ? {27'b0, w[24:20]}
                                                        : {{20{w[31]}}, w[31:20]};
            OPC_STORE:          r = {{20{w[31]}}, w[31:25], w[11:7]};
            OPC_BRANCH:         r = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            default:            r = '0;
        endcase
        return r;
    endfunction

    // Output monitor: pops the scoreboard on every handoff, checks hold under stall.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
                chk("stall_inst", bus.instOut, held_inst);
                chk("stall_err", {30'b0, bus.out_err}, {30'b0, held_err});
            end
            if (bus.out_valid && bus.out_ready) begin
                stalled = 1'b0;
                n_chk++;
                assert (q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_extra: observed output 0x%08h expected none", bus.instOut);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    if (e.err != 2'b00) exp_errc++;
                    if (e.rt) begin
                        chk("rt_opc", {25'b0, bus.instOut[6:0]}, {25'b0, e.opc});
                        chk("rt_err", {30'b0, bus.out_err}, 32'd0);
                        chk("rt_imm", extract(bus.instOut), e.imm);
                    end else begin
                        chk("sb_inst", bus.instOut, e.inst);
                        chk("sb_err", {30'b0, bus.out_err}, {30'b0, e.err});
                    end
                end
            end else if (bus.out_valid) begin
                stalled   = 1'b1;
                held_inst = bus.instOut;
                held_err  = bus.out_err;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (lo_cnt > 0) begin
            lo_cnt--;
            if (lo_cnt == 0) bus.out_ready = 1'b1;
        end
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input sb_t e, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] dimm);
        bit hs;
        hs = 1'b0;
        bus.in_valid = 1'b1;
        bus.opcode   = e.opc;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = dimm;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            hs = bus.in_ready;
            tick();
            if (hs) break;
        end
        bus.in_valid = 1'b0;
        if (hs) begin
            q.push_back(e);
            exp_enc++;
        end else begin
            n_chk++;
            n_fail++;
            $error("FAIL send_timeout: observed in_ready 0 for 50 cycles expected accept");
        end
    endtask

    task automatic drain();
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk("drain_empty", q.size(), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        q.delete();
        exp_enc  = 0;
        exp_errc = 0;
    endtask

    function automatic sb_t ex(input logic [6:0] opc, input logic [31:0] inst,
                               input logic [1:0] err);
        sb_t e;
        e.rt = 1'b0; e.opc = opc; e.inst = inst; e.err = err; e.imm = '0;
        return e;
    endfunction

    initial begin
        sb_t         e;
        logic [31:0] r;
        logic [31:0] li;
        logic [2:0]  f3;
        logic [6:0]  opcs [9];

        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.rd        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.funct3    = '0;
        bus.funct7    = '0;
        bus.imm       = '0;
        bus.out_ready = 1'b1;

        // Reset state
        do_reset(2);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_inst", bus.instOut, 32'd0);
        chk("rst_err", {30'b0, bus.out_err}, 32'd0);
        chk("rst_enc_cnt", {16'b0, bus.enc_count}, 32'd0);
        chk("rst_err_cnt", {24'b0, bus.err_count}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // LUI with latency check
        send(ex(OPC_LUI, 32'h1234_52B7, 2'b00), 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        chk("lat_n1_valid", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("lat_n2_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("lat_n2_inst", bus.instOut, 32'h1234_52B7);

        // ADDI in and out of range
        send(ex(OPC_OPIMM, 32'hFFF0_0093, 2'b00), 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        send(ex(OPC_OPIMM, 32'h8000_0093, 2'b01), 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        drain();
        chk("err_cnt_addi", {24'b0, bus.err_count}, 32'(exp_errc));
        chk("err_cnt_addi_1", {24'b0, bus.err_count}, 32'd1);

        // BEQ, misaligned BEQ, SLLI out of range, unsupported opcode
        send(ex(OPC_BRANCH, 32'h0020_8463, 2'b00), 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        send(ex(OPC_BRANCH, 32'h0020_8363, 2'b01), 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
        send(ex(OPC_OPIMM, 32'h0000_9093, 2'b01), 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32);
        send(ex(7'h7F, INST_NOP, 2'b10), 5'd3, 5'd4, 5'd5, 3'd2, 7'd9, 32'h1234_5678);
        drain();
        chk("err_cnt_mix", {24'b0, bus.err_count}, 32'(exp_errc));
        chk("enc_cnt_mix", {16'b0, bus.enc_count}, 32'(exp_enc));

        // Backpressure: out_ready low for 3 cycles, 4 back-to-back ADDs
        do_reset(1);
        bus.out_ready = 1'b0;
        lo_cnt        = 3;
        send(ex(OPC_OP, 32'h0020_80B3, 2'b00), 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        send(ex(OPC_OP, 32'h0020_8133, 2'b00), 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        send(ex(OPC_OP, 32'h0020_81B3, 2'b00), 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        send(ex(OPC_OP, 32'h0020_8233, 2'b00), 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        drain();
        chk("bp_enc_cnt", {16'b0, bus.enc_count}, 32'd4);

        // Random legal fields, round-tripped through the extractor, random out_ready
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                 OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
        rand_rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            r  = $urandom;
            f3 = 3'($urandom_range(0, 7));
            e.rt  = 1'b1;
            e.opc = opcs[$urandom_range(0, 8)];
            e.err = 2'b00;
            e.inst = '0;
            case (e.opc)
                OPC_LUI, OPC_AUIPC: li = r & 32'hFFFF_F000;
                OPC_JAL:            li = {{11{r[20]}}, r[20:1], 1'b0};
                OPC_BRANCH:         li = {{19{r[12]}}, r[12:1], 1'b0};
                OPC_OPIMM:          li = (f3[1:0] == 2'b01) ? {27'b0, r[4:0]}
                                                            : {{20{r[11]}}, r[11:0]};
                OPC_OP:             li = '0;
                default:            li = {{20{r[11]}}, r[11:0]};
            endcase
            e.imm = li;
            send(e, 5'($urandom), 5'($urandom), 5'($urandom), f3, 7'($urandom),
                 (e.opc == OPC_OP) ? r : li);
        end
        drain();
        chk("rt_enc_cnt", {16'b0, bus.enc_count}, 32'(exp_enc));
        chk("rt_err_cnt", {24'b0, bus.err_count}, 32'(exp_errc));

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(ex(OPC_OP, 32'h0020_80B3, 2'b00), 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        send(ex(OPC_OP, 32'h0020_8133, 2'b00), 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_enc_cnt", {16'b0, bus.enc_count}, 32'd0);
        chk("mid_rst_err_cnt", {24'b0, bus.err_count}, 32'd0);
        rst = 1'b0;
        q.delete();
        exp_enc  = 0;
        exp_errc = 0;
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_no_output", {31'b0, bus.out_valid}, 32'd0);
        chk("post_rst_sb_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
